// File: rtl/serial_alu_sequencer_pkg.sv
// Shared types for the serial add/subtract sequencer: FSM state encoding,
// the NZCV flag record and the bit-counter width helper.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Counter must hold 0..width-1; keep at least one bit for tiny widths.
    function automatic int cnt_width(input int width);
        if (width <= 2) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/serial_alu_sequencer_if.sv
// Request/result handshake bundle for serial_alu_sequencer.
// master = requester/consumer side, slave = the arithmetic unit.
interface serial_alu_sequencer_if #(
    parameter int WIDTH = 64
) ();
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             busy;

    modport master (
        output start_valid, a, b, sub, result_ready,
        input  start_ready, result_valid, result,
        input  flag_n, flag_z, flag_c, flag_v, busy
    );

    modport slave (
        input  start_valid, a, b, sub, result_ready,
        output start_ready, result_valid, result,
        output flag_n, flag_z, flag_c, flag_v, busy
    );
endinterface

// File: rtl/serial_alu_sequencer_bitslice.sv
// One-bit full-adder cell with its carry flop. The carry flop is preset to
// the subtract flag on load (two's complement +1) and advances on each step.
// ovf is the carry into the current slice XOR its carry out; sampled on the
// MSB step it is the signed overflow flag.
module serial_alu_bitslice (
    input  logic clk,
    input  logic reset_n,
    input  logic a_bit,
    input  logic b_bit,
    input  logic load,
    input  logic load_cin,
    input  logic step,
    output logic sum,
    output logic cout,
    output logic ovf
);
    logic carry_r;

    assign sum  = a_bit ^ b_bit ^ carry_r;
    assign cout = (a_bit & b_bit) | (a_bit & carry_r) | (b_bit & carry_r);
    assign ovf  = carry_r ^ cout;

    // Carry flop: preset on operation load, ripple forward one bit per step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            carry_r <= 1'b0;
        end else if (load) begin
            carry_r <= load_cin;
        end else if (step) begin
            carry_r <= cout;
        end
    end
endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial WIDTH-bit add/subtract unit with NZCV flags, LSB first, one bit
// per clock through serial_alu_bitslice.
// Optional build macro: SERIAL_ALU_BACK2BACK_EN lets a new request be taken
// in the same cycle the result is consumed, skipping the IDLE cycle.
module serial_alu_sequencer
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    serial_alu_sequencer_if.slave  bus
);
    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic [WIDTH-1:0] result_r;
    flags_t           flags_r;
    logic [CW-1:0]    count_r;
    logic             start_ready_s;
    logic             load_s;
    logic             step_s;
    logic             last_s;
    logic             sum_s;
    logic             cout_s;
    logic             ovf_s;
    logic [WIDTH-1:0] done_res_s;

    serial_alu_bitslice u_slice (
        .clk      (clk),
        .reset_n  (reset_n),
        .a_bit    (a_sh_r[0]),
        .b_bit    (b_sh_r[0]),
        .load     (load_s),
        .load_cin (bus.sub),
        .step     (step_s),
        .sum      (sum_s),
        .cout     (cout_s),
        .ovf      (ovf_s)
    );

    // Result as it will stand once the current (final) sum bit lands at the MSB.
    assign done_res_s = {sum_s, res_sh_r[WIDTH-1:1]};

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt_s   = state_r;
        start_ready_s = 1'b0;
        load_s        = 1'b0;
        step_s        = 1'b0;
        last_s        = 1'b0;
        case (state_r)
            IDLE: begin
                start_ready_s = 1'b1;
                if (bus.start_valid) begin
                    load_s      = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (count_r == LAST_CNT) begin
                    last_s      = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
`ifdef SERIAL_ALU_BACK2BACK_EN
                start_ready_s = bus.result_ready;
                if (bus.result_ready && bus.start_valid) begin
                    load_s      = 1'b1;
                    state_nxt_s = RUN;
                end else if (bus.result_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
`else
                if (bus.result_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
`endif
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand/result shift registers, bit counter and the DONE-entry result/flag capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_sh_r <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            flags_r  <= 4'b0000;
            count_r  <= {CW{1'b0}};
        end else if (load_s) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.sub ? ~bus.b : bus.b;
            count_r <= {CW{1'b0}};
        end else if (step_s) begin
            a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
            res_sh_r <= done_res_s;
            count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
            if (last_s) begin
                result_r  <= done_res_s;
                flags_r.n <= sum_s;
                flags_r.z <= (done_res_s == {WIDTH{1'b0}});
                flags_r.c <= cout_s;
                flags_r.v <= ovf_s;
            end
        end
    end

    assign bus.start_ready  = start_ready_s;
    assign bus.result_valid = (state_r == DONE);
    assign bus.busy         = (state_r == RUN);
    assign bus.result       = result_r;
    assign bus.flag_n       = flags_r.n;
    assign bus.flag_z       = flags_r.z;
    assign bus.flag_c       = flags_r.c;
    assign bus.flag_v       = flags_r.v;
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed, table-driven bench for serial_alu_sequencer (WIDTH=8 plus one
// WIDTH=64 instance). Honours SERIAL_ALU_BACK2BACK_EN for the throughput case.
module tb_serial_alu_sequencer;
    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

`ifdef SERIAL_ALU_BACK2BACK_EN
    localparam int B2B_GAP = 9;
`else
    localparam int B2B_GAP = 10;
`endif

    serial_alu_sequencer_if #(.WIDTH(8))  bus8 ();
    serial_alu_sequencer_if #(.WIDTH(64)) bus64 ();

    serial_alu_sequencer #(.WIDTH(8)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8)
    );

    serial_alu_sequencer #(.WIDTH(64)) u_dut64 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] exp_res;
        logic [3:0] exp_nzcv;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] nzcv8();
        return {bus8.flag_n, bus8.flag_z, bus8.flag_c, bus8.flag_v};
    endfunction

    // Wait (bounded) for result_valid on the 8-bit unit; returns edges waited.
    task automatic wait_valid8(output int n);
        n = 0;
        while (!bus8.result_valid && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    // One complete operation with result_ready high; checks latency, result, flags, pulse width.
    task automatic do_op(input vec_t v, input string nm);
        int n;
        check({nm, "_start_ready"}, 64'(bus8.start_ready), 64'd1);
        bus8.a = v.a;
        bus8.b = v.b;
        bus8.sub = v.sub;
        bus8.start_valid = 1'b1;
        bus8.result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start_valid = 1'b0;
        bus8.a = ~v.a;
        bus8.b = 8'h5A;
        bus8.sub = ~v.sub;
        wait_valid8(n);
        check({nm, "_latency"}, 64'(n), 64'd8);
        check({nm, "_result"}, 64'(bus8.result), 64'(v.exp_res));
        check({nm, "_nzcv"}, 64'(nzcv8()), 64'(v.exp_nzcv));
        @(posedge clk);
        @(negedge clk);
        check({nm, "_pulse"}, 64'(bus8.result_valid), 64'd0);
    endtask

    initial begin
        int n;
        int gap;
        int seen;
        bit dropped;
        n_vec = 0;
        n_err = 0;

        vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 4'b1001};
        vecs[1] = '{8'h05, 8'h05, 1'b1, 8'h00, 4'b0110};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 4'b0110};
        vecs[3] = '{8'h03, 8'h05, 1'b1, 8'hFE, 4'b1000};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011};
        vecs[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 4'b0000};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 4'b0111};
        vecs[7] = '{8'h00, 8'h01, 1'b1, 8'hFF, 4'b1000};

        reset_n = 1'b0;
        bus8.start_valid = 1'b0;
        bus8.a = 8'h00;
        bus8.b = 8'h00;
        bus8.sub = 1'b0;
        bus8.result_ready = 1'b0;
        bus64.start_valid = 1'b0;
        bus64.a = 64'h0;
        bus64.b = 64'h0;
        bus64.sub = 1'b0;
        bus64.result_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state.
        check("rst_result", 64'(bus8.result), 64'd0);
        check("rst_nzcv", 64'(nzcv8()), 64'd0);
        check("rst_valid", 64'(bus8.result_valid), 64'd0);
        check("rst_busy", 64'(bus8.busy), 64'd0);
        check("rst_start_ready", 64'(bus8.start_ready), 64'd1);

        // Table-driven operations.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: sub 3-5 held for 10 cycles with result_ready low.
        bus8.a = 8'h03;
        bus8.b = 8'h05;
        bus8.sub = 1'b1;
        bus8.start_valid = 1'b1;
        bus8.result_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("bp_busy", 64'(bus8.busy), 64'd1);
        check("bp_run_start_ready", 64'(bus8.start_ready), 64'd0);
        bus8.a = 8'h11;
        bus8.b = 8'h22;
        bus8.sub = 1'b0;
        wait_valid8(n);
        check("bp_latency", 64'(n), 64'd8);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", 64'(bus8.result_valid), 64'd1);
            check("bp_hold_result", 64'(bus8.result), 64'hFE);
            check("bp_hold_nzcv", 64'(nzcv8()), 64'b1000);
            check("bp_hold_start_ready", 64'(bus8.start_ready), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        bus8.start_valid = 1'b0;
        bus8.result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", 64'(bus8.result_valid), 64'd0);
        check("bp_release_start_ready", 64'(bus8.start_ready), 64'd1);

        // Reset in RUN cycle 4 aborts the operation.
        bus8.a = 8'h44;
        bus8.b = 8'h11;
        bus8.sub = 1'b0;
        bus8.start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        check("mid_rst_result", 64'(bus8.result), 64'd0);
        check("mid_rst_nzcv", 64'(nzcv8()), 64'd0);
        check("mid_rst_busy", 64'(bus8.busy), 64'd0);
        check("mid_rst_valid", 64'(bus8.result_valid), 64'd0);
        check("mid_rst_start_ready", 64'(bus8.start_ready), 64'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.result_valid || bus8.busy) begin
                seen++;
            end
        end
        check("mid_rst_no_result", 64'(seen), 64'd0);
        do_op(vecs[5], "after_rst");

        // Back-to-back: start_valid held, result_ready high.
        bus8.a = 8'h01;
        bus8.b = 8'h02;
        bus8.sub = 1'b0;
        bus8.start_valid = 1'b1;
        bus8.result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.a = 8'h05;
        bus8.b = 8'h03;
        wait_valid8(n);
        check("b2b_first_latency", 64'(n), 64'd8);
        check("b2b_first_result", 64'(bus8.result), 64'h03);
        gap = 0;
        dropped = 1'b0;
        do begin
            @(posedge clk);
            @(negedge clk);
            gap++;
            if (!dropped && bus8.busy) begin
                bus8.start_valid = 1'b0;
                dropped = 1'b1;
            end
        end while (!bus8.result_valid && gap < 40);
        check("b2b_gap", 64'(gap), 64'(B2B_GAP));
        check("b2b_second_result", 64'(bus8.result), 64'h08);
        bus8.start_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b2b_pulse", 64'(bus8.result_valid), 64'd0);

        // WIDTH=64 signed overflow case.
        bus64.a = 64'h7FFF_FFFF_FFFF_FFFF;
        bus64.b = 64'h0000_0000_0000_0001;
        bus64.sub = 1'b0;
        bus64.start_valid = 1'b1;
        bus64.result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus64.start_valid = 1'b0;
        bus64.a = 64'h0;
        n = 0;
        while (!bus64.result_valid && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("w64_latency", 64'(n), 64'd64);
        check("w64_result", bus64.result, 64'h8000_0000_0000_0000);
        check("w64_nzcv", 64'({bus64.flag_n, bus64.flag_z, bus64.flag_c, bus64.flag_v}), 64'b1001);
        @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
